key_debounce: RTL and testbench

- Upstream of the sound player. Converts raw per-key hit flags from the projected-keyboard vision stage into a stable, debounced key bitmask `key_num[16:0]`.
- Debouncing is counted in vision sample strobes, not clock cycles, so flicker between frames never reaches the player.
- Caps polyphony so that at most MAX_ACTIVE keys are presented. A one-cycle change pulse is produced for downstream restart logic.

---
 rtl/key_debounce.sv | 75 +++++++
 tb/tb_key_debounce.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// Purpose: debounce raw vision key hits per sample strobe and cap polyphony to the lowest MAX_ACTIVE keys.
// Latency: a strobe edge that flips a key's stable state shows on key_num one clock later.
// Backpressure: none; sample_en is a free-running strobe and the outputs are registered every clock.
module key_debounce #(
    parameter int NUM_KEYS        = 17,
    parameter int PRESS_SAMPLES   = 4,
    parameter int RELEASE_SAMPLES = 8,
    parameter int MAX_ACTIVE      = 2
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                sample_en,
    input  logic [NUM_KEYS-1:0] raw_keys,
    output logic [NUM_KEYS-1:0] key_num,
    output logic                key_changed,
    output logic [4:0]          active_count
);

    // Counter value at which a disagreeing sample completes qualification.
    localparam logic [7:0] PRESS_LAST   = 8'(PRESS_SAMPLES - 1);
    localparam logic [7:0] RELEASE_LAST = 8'(RELEASE_SAMPLES - 1);
    localparam logic [4:0] ACTIVE_LIMIT = 5'(MAX_ACTIVE);

    logic [NUM_KEYS-1:0] stable;
    logic [7:0]          cnt [NUM_KEYS];
    logic [NUM_KEYS-1:0] limited;
    logic [4:0]          kept;

    // Per-key debounce: count consecutive disagreeing strobes; any agreeing strobe restarts the count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stable <= '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                cnt[i] <= '0;
            end
        end else if (sample_en) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (raw_keys[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == (stable[i] ? RELEASE_LAST : PRESS_LAST)) begin
                    stable[i] <= ~stable[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 8'd1;
                end
            end
        end
    end

    // Polyphony limit: keep the first MAX_ACTIVE stable keys scanning up from bit 0.
    always_comb begin
        limited = '0;
        kept    = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (stable[i] && (kept < ACTIVE_LIMIT)) begin
                limited[i] = 1'b1;
                kept       = kept + 5'd1;
            end
        end
    end

    // Output register: mask, its popcount, and a pulse whenever the mask takes a new value.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            key_num      <= '0;
            key_changed  <= 1'b0;
            active_count <= '0;
        end else begin
            key_num      <= limited;
            key_changed  <= (limited != key_num);
            active_count <= kept;
        end
    end

endmodule

// File: tb/tb_key_debounce.sv
// Purpose: randomized and scripted stimulus for key_debounce, checked by a queue-based scoreboard.
// Latency: expected masks are queued with the edge at which key_changed must pulse.
// Backpressure: none; the monitor compares every negative clock edge.
module tb_key_debounce;

    localparam int NK   = 17;
    localparam int PRS  = 4;
    localparam int REL  = 8;
    localparam int MAXA = 2;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          sample_en = 1'b0;
    logic [NK-1:0] raw_keys = '0;
    logic [NK-1:0] key_num;
    logic          key_changed;
    logic [4:0]    active_count;

    key_debounce #(
        .NUM_KEYS(NK), .PRESS_SAMPLES(PRS), .RELEASE_SAMPLES(REL), .MAX_ACTIVE(MAXA)
    ) dut (
        .clock(clock), .reset_n(reset_n), .sample_en(sample_en), .raw_keys(raw_keys),
        .key_num(key_num), .key_changed(key_changed), .active_count(active_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        int            e;
        logic [NK-1:0] m;
    } exp_t;

    exp_t          exp_q[$];
    int            checks = 0;
    int            failures = 0;
    int            edge_no = 0;
    bit            in_reset = 1'b1;
    logic [NK-1:0] exp_keynum = '0;
    logic [NK-1:0] last_pushed = '0;

    // Reference model: each key remembers its raw samples since it last changed state.
    bit            m_stable [NK];
    bit            m_hist   [NK][$];

    function automatic void model_clear();
        for (int i = 0; i < NK; i++) begin
            m_stable[i] = 1'b0;
            m_hist[i].delete();
        end
    endfunction

    // A key flips once its most recent `threshold` samples all disagree with its state.
    function automatic void model_sample(input logic [NK-1:0] raw);
        for (int i = 0; i < NK; i++) begin
            int  thr;
            bit  all_diff;
            thr = m_stable[i] ? REL : PRS;
            m_hist[i].push_back(raw[i]);
            if (m_hist[i].size() > 300) void'(m_hist[i].pop_front());
            all_diff = (m_hist[i].size() >= thr);
            for (int k = 0; k < thr && all_diff; k++) begin
                if (m_hist[i][m_hist[i].size() - 1 - k] == m_stable[i]) all_diff = 1'b0;
            end
            if (all_diff) begin
                m_stable[i] = ~m_stable[i];
                m_hist[i].delete();
            end
        end
    endfunction

    // Lowest set bits first, isolated arithmetically with x & -x.
    function automatic logic [NK-1:0] model_mask();
        logic [NK-1:0] s, out, low;
        s = '0;
        for (int i = 0; i < NK; i++) s[i] = m_stable[i];
        out = '0;
        for (int n = 0; n < MAXA; n++) begin
            low = s & (~s + 1'b1);
            out = out | low;
            s   = s & ~low;
        end
        return out;
    endfunction

    function automatic void fail_line(input string name, input logic [31:0] act, input logic [31:0] req);
        failures++;
        $display("FAIL %s at edge %0d: got 0x%0h expected 0x%0h", name, edge_no, act, req);
    endfunction

    // One clock: drive inputs, advance the model at the edge, queue any new mask.
    task automatic step(input logic sen, input logic [NK-1:0] raw);
        logic [NK-1:0] m;
        sample_en = sen;
        raw_keys  = raw;
        @(posedge clock);
        edge_no++;
        exp_keynum = model_mask();
        if (sen) model_sample(raw);
        m = model_mask();
        if (m != last_pushed) begin
            exp_q.push_back('{e: edge_no + 1, m: m});
            last_pushed = m;
        end
        #1;
    endtask

    // A strobe followed by idle cycles whose raw_keys noise must be ignored.
    task automatic strobe(input logic [NK-1:0] raw, input int gap);
        step(1'b1, raw);
        for (int g = 0; g < gap; g++) step(1'b0, NK'($urandom));
    endtask

    task automatic strobes(input logic [NK-1:0] raw, input int n);
        for (int s = 0; s < n; s++) strobe(raw, int'($urandom_range(1, 11)));
    endtask

    // Asynchronous reset asserted between edges; outputs must clear before the next edge.
    task automatic do_reset();
        in_reset = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (key_num != '0) fail_line("reset_key_num", 32'(key_num), 32'd0);
        checks++;
        if (active_count != 5'd0) fail_line("reset_active_count", 32'(active_count), 32'd0);
        checks++;
        if (key_changed != 1'b0) fail_line("reset_key_changed", 32'(key_changed), 32'd0);
        model_clear();
        exp_q.delete();
        last_pushed = '0;
        exp_keynum  = '0;
        sample_en   = 1'b0;
        @(posedge clock); edge_no++;
        @(posedge clock); edge_no++;
        #2;
        reset_n  = 1'b1;
        in_reset = 1'b0;
    endtask

    // Monitor: every negedge compares the mask and popcount; key_changed pops the scoreboard.
    initial begin
        forever begin
            @(negedge clock);
            if (!in_reset && reset_n) begin
                bit due;
                checks++;
                if (key_num != exp_keynum) fail_line("key_num", 32'(key_num), 32'(exp_keynum));
                checks++;
                if (32'(active_count) != $countones(exp_keynum))
                    fail_line("active_count", 32'(active_count), 32'($countones(exp_keynum)));
                due = (exp_q.size() > 0) && (exp_q[0].e == edge_no);
                checks++;
                if (key_changed != due) fail_line("key_changed", 32'(key_changed), 32'(due));
                if (key_changed && exp_q.size() > 0) begin
                    checks++;
                    if (key_num != exp_q[0].m) fail_line("changed_mask", 32'(key_num), 32'(exp_q[0].m));
                end
                if (due) void'(exp_q.pop_front());
                while (exp_q.size() > 0 && exp_q[0].e < edge_no) begin
                    fail_line("missed_pulse", 32'(exp_q[0].e), 32'(edge_no));
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NK-1:0] target, noise;
        model_clear();
        do_reset();

        // Press key 0, then release it through the longer hysteresis.
        strobes(17'h00001, 3);
        strobes(17'h00001, 1);
        strobes(17'h00000, 7);
        strobes(17'h00000, 1);

        // Glitch on key 5 interrupts qualification; a clean run then sets it.
        strobes(17'h00020, 3);
        strobes(17'h00000, 1);
        strobes(17'h00020, 3);
        strobes(17'h00020, 1);
        strobes(17'h00000, 8);

        // Polyphony: three keys pressed, only the two lowest shown until key 2 releases.
        strobes(17'h10204, 4);
        strobes(17'h10200, 8);
        strobes(17'h00000, 8);

        // Reset mid-qualification with key 7 already shown and key 3 one strobe short.
        strobes(17'h00080, 4);
        strobes(17'h00088, 3);
        do_reset();
        strobes(17'h00008, 3);
        strobes(17'h00008, 1);
        strobes(17'h00000, 8);

        // Continuous sampling: every cycle is a strobe; then hold with no raw changes.
        for (int c = 0; c < 6; c++) step(1'b1, 17'h10000);
        for (int c = 0; c < 20; c++) step(1'b1, 17'h10000);
        for (int c = 0; c < 30; c++) step(1'b0, NK'($urandom));
        for (int c = 0; c < 10; c++) step(1'b1, 17'h00000);

        // Random phase: slowly moving intended keys plus sparse per-sample flicker.
        target = '0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 19) == 0) target[$urandom_range(0, NK - 1)] ^= 1'b1;
            noise = '0;
            if ($urandom_range(0, 3) == 0) noise[$urandom_range(0, NK - 1)] = 1'b1;
            step($urandom_range(0, 2) == 0, target ^ noise);
        end
        for (int c = 0; c < 5; c++) step(1'b0, '0);

        checks++;
        if (exp_q.size() != 0) fail_line("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
